// File: rtl/writeback_stage_if.sv
// Execute-to-writeback handshake bundle for the rv_64im core.
// Execute drives the completed instruction; writeback returns ex_ready.
interface writeback_stage_if #(
  parameter int XLEN = 64
);
  logic            ex_valid;
  logic            ex_ready;
  logic [4:0]      ex_rd;
  logic            ex_rd_en;
  logic [1:0]      ex_sel;
  logic            ex_word;
  logic [2:0]      ex_ld_funct3;
  logic [2:0]      ex_ld_offset;
  logic [XLEN-1:0] ex_alu_res;
  logic [XLEN-1:0] ex_md_res;
  logic [XLEN-1:0] ex_ld_data;
  logic [XLEN-1:0] ex_pc;

  modport master (
    output ex_valid, ex_rd, ex_rd_en,
    output ex_sel, ex_word,
    output ex_ld_funct3, ex_ld_offset,
    output ex_alu_res, ex_md_res,
    output ex_ld_data, ex_pc,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_rd, ex_rd_en,
    input  ex_sel, ex_word,
    input  ex_ld_funct3, ex_ld_offset,
    input  ex_alu_res, ex_md_res,
    input  ex_ld_data, ex_pc,
    output ex_ready
  );
endinterface

// File: rtl/writeback_stage.sv
// rv_64im writeback: result formatting, 2-entry skid queue,
// register-file write port, forwarding view and instret counter.
module writeback_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  writeback_stage_if.slave ex,
  input  logic            rf_ready,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic [63:0]     instret
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic            wr;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  state_t state, state_nxt;
  entry_t out_q, skid_q, new_e;

  logic [XLEN-1:0] ld_s, ld_v, ar, res;
  logic accept, drain, out_valid;
  logic load_out, load_skid, move_skid;

  always_comb begin
    ld_s = ex.ex_ld_data >> {ex.ex_ld_offset, 3'b000};
    unique case (ex.ex_ld_funct3)
      3'b000:  ld_v = {{56{ld_s[7]}}, ld_s[7:0]};
      3'b001:  ld_v = {{48{ld_s[15]}}, ld_s[15:0]};
      3'b010:  ld_v = {{32{ld_s[31]}}, ld_s[31:0]};
      3'b011:  ld_v = ld_s;
      3'b100:  ld_v = {56'd0, ld_s[7:0]};
      3'b101:  ld_v = {48'd0, ld_s[15:0]};
      3'b110:  ld_v = {32'd0, ld_s[31:0]};
      default: ld_v = '0;
    endcase
  end

  always_comb begin
    ar = ex.ex_sel[0] ? ex.ex_md_res
                      : ex.ex_alu_res;
    if (ex.ex_word)
      ar = {{32{ar[31]}}, ar[31:0]};
    unique case (ex.ex_sel)
      2'b10:   res = ld_v;
      2'b11:   res = ex.ex_pc + 64'd4;
      default: res = ar;
    endcase
    new_e.wr   = ex.ex_rd_en & (|ex.ex_rd);
    new_e.rd   = ex.ex_rd;
    new_e.data = res;
  end

  assign ex.ex_ready = (state != FULL);
  assign out_valid   = (state != EMPTY);
  assign accept      = ex.ex_valid & ex.ex_ready;
  assign drain       = out_valid & rf_ready;

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          load_out  = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (drain) begin
          move_skid = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      instret <= '0;
    end else begin
      state <= state_nxt;
      if (load_out)
        out_q <= new_e;
      else if (move_skid)
        out_q <= skid_q;
      if (load_skid)
        skid_q <= new_e;
      if (drain)
        instret <= instret + 64'd1;
    end
  end

  assign rf_we     = out_valid & out_q.wr;
  assign rf_waddr  = out_q.rd;
  assign rf_wdata  = out_q.data;
  assign fwd_valid = out_valid & out_q.wr;
  assign fwd_rd    = out_q.rd;
  assign fwd_data  = out_q.data;

endmodule
